// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mdu_ctrl_pkg
// Brief    : Shared encodings and default latencies for the MDU controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package mdu_ctrl_pkg;

   // E-stage MDU operation encodings; code 7 behaves as MD_NONE
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   // E-stage read-select encodings
   localparam logic [1:0] RD_NONE = 2'd0;
   localparam logic [1:0] RD_HI   = 2'd1;
   localparam logic [1:0] RD_LO   = 2'd2;

   // Default busy latencies
   localparam int MULT_CYCLES_DFLT = 5;
   localparam int DIV_CYCLES_DFLT  = 10;

   // Controller states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mdu_calc
// Brief    : Combinational HI/LO result generator for mult/multu/div/divu.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mdu_calc
   import mdu_ctrl_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div0_o
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_signed_div;
   logic        w_rs_neg;
   logic        w_rt_neg;
   logic        w_div0;
   logic [31:0] w_dvd;
   logic [31:0] w_dvs_raw;
   logic [31:0] w_dvs;
   logic [31:0] w_quo_u;
   logic [31:0] w_rem_u;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
   assign w_prod_u = {32'd0, rs_i} * {32'd0, rt_i};

   // Signed divide runs on magnitudes; |0x80000000| still fits in 32 unsigned
   // bits, so 0x80000000 / -1 naturally yields 0x80000000 rem 0.
   assign w_signed_div = (op_i == MD_DIV);
   assign w_rs_neg     = w_signed_div & rs_i[31];
   assign w_rt_neg     = w_signed_div & rt_i[31];
   assign w_dvd        = w_rs_neg ? (32'd0 - rs_i) : rs_i;
   assign w_dvs_raw    = w_rt_neg ? (32'd0 - rt_i) : rt_i;
   assign w_div0       = (rt_i == 32'd0);
   // A dummy divisor keeps the divider well defined when the result is discarded
   assign w_dvs        = w_div0 ? 32'd1 : w_dvs_raw;
   assign w_quo_u      = w_dvd / w_dvs;
   assign w_rem_u      = w_dvd % w_dvs;
   assign w_quo        = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_quo_u) : w_quo_u;
   assign w_rem        = w_rs_neg ? (32'd0 - w_rem_u) : w_rem_u;

   // Select the result pair for the requested operation
   always_comb begin
      hi_o   = 32'd0;
      lo_o   = 32'd0;
      div0_o = 1'b0;
      case (op_i)
         MD_MULT:  {hi_o, lo_o} = w_prod_s;
         MD_MULTU: {hi_o, lo_o} = w_prod_u;
         MD_DIV, MD_DIVU: begin
            hi_o   = w_rem;
            lo_o   = w_quo;
            div0_o = w_div0;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mdu_ctrl
// Brief    : HI/LO owner and multi-cycle mult/div sequencer with pipeline
//            freeze generation (PC enable, F/D enable, D/E clear).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DFLT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  E_md_op,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   input  logic [1:0]  E_md_rdsel,
   input  logic        D_md_use,
   input  logic        hazard_stall,
   output logic [31:0] E_md_res,
   output logic        busy,
   output logic        PC_en,
   output logic        FD_en,
   output logic        DE_clr
);

   localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

   mdu_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        nowrite_q, nowrite_d;

   logic        w_is_muldiv;
   logic        w_is_div;
   logic        w_start;
   logic        w_md_stall;
   logic        w_stall;
   logic [31:0] w_calc_hi;
   logic [31:0] w_calc_lo;
   logic        w_calc_div0;

   mdu_calc u_calc (
      .op_i   (E_md_op),
      .rs_i   (E_rs),
      .rt_i   (E_rt),
      .hi_o   (w_calc_hi),
      .lo_o   (w_calc_lo),
      .div0_o (w_calc_div0)
   );

   assign w_is_muldiv = (E_md_op == MD_MULT) || (E_md_op == MD_MULTU) ||
                        (E_md_op == MD_DIV)  || (E_md_op == MD_DIVU);
   assign w_is_div    = (E_md_op == MD_DIV)  || (E_md_op == MD_DIVU);
   assign w_start     = w_is_muldiv && (state_q == ST_IDLE);
   assign busy        = (state_q == ST_BUSY);

   // Freeze F/D and bubble D/E while an MDU user in D would see stale HI/LO
   assign w_md_stall  = D_md_use & (busy | w_start);
   assign w_stall     = w_md_stall | hazard_stall;
   assign PC_en       = ~w_stall;
   assign FD_en       = ~w_stall;
   assign DE_clr      = w_stall;

   // Committed HI/LO read; never bypasses pending results
   always_comb begin
      E_md_res = 32'd0;
      case (E_md_rdsel)
         RD_HI:   E_md_res = hi_q;
         RD_LO:   E_md_res = lo_q;
         default: E_md_res = 32'd0;
      endcase
   end

   // Next-state: capture on start, count down while busy, commit on last cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      nowrite_d = nowrite_q;
      case (state_q)
         ST_IDLE: begin
            if (w_start) begin
               pend_hi_d = w_calc_hi;
               pend_lo_d = w_calc_lo;
               nowrite_d = w_calc_div0;
               cnt_d     = w_is_div ? C_DIV_CNT : C_MULT_CNT;
               state_d   = ST_BUSY;
            end else if (E_md_op == MD_MTHI) begin
               hi_d = E_rs;
            end else if (E_md_op == MD_MTLO) begin
               lo_d = E_rs;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_IDLE;
               if (!nowrite_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
      endcase
   end

   // State register with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         nowrite_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         nowrite_q <= nowrite_d;
      end
   end

endmodule
`default_nettype wire
